// File: rtl/wb_regfile_pkg.sv
// Shared widths and constants for the write-back register file.
package wb_regfile_pkg;

    // Default register bus and register address bus widths.
    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;

    // Default number of architectural registers.
    localparam int REG_NUM = 32;

    // Register 0 reads as zero and is never written or tracked.
    localparam int ZERO_REG = 0;

    // Level of rst at which the block is held in reset.
    localparam logic RST_ACTIVE = 1'b0;

    // Default width of each pending-write counter.
    localparam int PEND_CNT_W = 2;

endpackage : wb_regfile_pkg

// File: rtl/wb_pending_ctr.sv
// Saturating up/down counter of in-flight writes to one register.
// Increments on issue, decrements on write-back, holds at both ends.
module wb_pending_ctr
    import wb_regfile_pkg::*;
#(
    parameter int W = PEND_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         nonzero
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // Count pending writers; inc and dec together cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: state registers always use non-blocking assignments so every
            // flop samples pre-edge values regardless of block evaluation order.
            count <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   if (count != CNT_MAX) count <= count + 1'b1;
                2'b01:   if (count != '0)      count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign nonzero = |count;

endmodule : wb_pending_ctr

// File: rtl/wb_regfile.sv
// Architectural register file with two combinational read ports and a
// per-register pending-write scoreboard.
// Optional feature: define REGFILE_BYPASS_EN to forward the WB write to the
// read ports in the same cycle and to drop busy when that write retires the
// last outstanding writer of the register being read.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_BUS_W,
    parameter int NREG   = REG_NUM,
    parameter int PEND_W = PEND_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_waddr,
    output logic              busy1,
    output logic              busy2
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs   [NREG];
    logic [PEND_W-1:0] pend   [NREG];
    logic [NREG-1:0]   pend_nz;

    logic wr_ok;
    logic hit1;
    logic hit2;

    assign wr_ok = we && (int'(waddr) != ZERO_REG) && (int'(waddr) < NREG);
    assign hit1  = we && (waddr == raddr1);
    assign hit2  = we && (waddr == raddr2);

    // Register array: write port commits on the edge, register 0 stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array is reset because a cleared register file is
            // architecturally visible after reset, not merely an init nicety.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // Register 0 is never tracked.
    assign pend[0]    = '0;
    assign pend_nz[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_pend
        wb_pending_ctr #(
            .W (PEND_W)
        ) u_ctr (
            .clk     (clk),
            .rst     (rst),
            .inc     (issue_we && (issue_waddr == ADDR_W'(g))),
            .dec     (we && (waddr == ADDR_W'(g))),
            .count   (pend[g]),
            .nonzero (pend_nz[g])
        );
    end

    // Read port 1: data select and hazard flag, forced quiet during reset.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        rdata1 = '0;
        busy1  = 1'b0;
        if (rst != RST_ACTIVE && re1 && int'(raddr1) != ZERO_REG && int'(raddr1) < NREG) begin
            rdata1 = (BYPASS && hit1) ? wdata : regs[raddr1];
            busy1  = pend_nz[raddr1] && !(BYPASS && hit1 && pend[raddr1] == PEND_ONE);
        end
    end

    // Read port 2: same selection as port 1 on its own address.
    always_comb begin
        rdata2 = '0;
        busy2  = 1'b0;
        if (rst != RST_ACTIVE && re2 && int'(raddr2) != ZERO_REG && int'(raddr2) < NREG) begin
            rdata2 = (BYPASS && hit2) ? wdata : regs[raddr2];
            busy2  = pend_nz[raddr2] && !(BYPASS && hit2 && pend[raddr2] == PEND_ONE);
        end
    end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile; expectations follow REGFILE_BYPASS_EN.
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        issue_we;
    logic [4:0]  issue_waddr;
    logic        busy1;
    logic        busy2;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic        bz1;
        logic [31:0] rd2;
        logic        bz2;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    wb_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .re1         (re1),
        .raddr1      (raddr1),
        .rdata1      (rdata1),
        .re2         (re2),
        .raddr2      (raddr2),
        .rdata2      (rdata2),
        .issue_we    (issue_we),
        .issue_waddr (issue_waddr),
        .busy1       (busy1),
        .busy2       (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2,
                         input logic iw, input logic [4:0] ia);
        we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
        issue_we = iw; issue_waddr = ia;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 1, 5, 1, 5, 0, 0);
        sb.push_back('{"reset_hold", 32'h0, 1'b0, 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();
        rst = 1'b1;
        tick();

        drive(0, 0, 0, 1, 5, 0, 0, 0, 0);
        sb.push_back('{"read_after_reset", 32'h0, 1'b0, 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        drive(1, 0, 32'hDEADBEEF, 1, 0, 1, 0, 0, 0);
        sb.push_back('{"write_r0_same", 32'h0, 1'b0, 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        sb.push_back('{"read_r0_after", 32'h0, 1'b0, 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();
    endtask

    task automatic test_write_latency();
        drive(1, 3, 32'h12345678, 0, 0, 1, 3, 0, 0);
        sb.push_back('{"wr3_same", 32'h0, 1'b0, BYP ? 32'h12345678 : 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        // Port 1 points at r3 but is disabled, so it must stay zero.
        drive(0, 0, 0, 0, 3, 1, 3, 0, 0);
        sb.push_back('{"wr3_next", 32'h0, 1'b0, 32'h12345678, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();
    endtask

    task automatic test_bypass();
        drive(1, 7, 32'hA5A5A5A5, 1, 7, 1, 7, 0, 0);
        sb.push_back('{"byp7_same", BYP ? 32'hA5A5A5A5 : 32'h0, 1'b0, BYP ? 32'hA5A5A5A5 : 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        drive(0, 0, 0, 1, 7, 1, 3, 0, 0);
        sb.push_back('{"r7_after", 32'hA5A5A5A5, 1'b0, 32'h12345678, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        // Issue does not affect busy in its own cycle.
        drive(0, 0, 0, 1, 9, 1, 3, 1, 9);
        sb.push_back('{"issue9_same", 32'h0, 1'b0, 32'h12345678, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        // Instruction in flight through EX and MEM.
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1, 9, 1, 3, 0, 0);
            sb.push_back('{$sformatf("busy9_stage%0d", i), 32'h0, 1'b1, 32'h12345678, 1'b0});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
                errors++;
                $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
            end
            tick();
        end

        drive(1, 9, 32'hCAFEF00D, 1, 9, 1, 9, 0, 0);
        sb.push_back('{"wb9", BYP ? 32'hCAFEF00D : 32'h0, !BYP, BYP ? 32'hCAFEF00D : 32'h0, !BYP});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        drive(0, 0, 0, 1, 9, 1, 9, 0, 0);
        sb.push_back('{"after9", 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();
    endtask

    task automatic test_saturation();
        logic [31:0] prev;
        // Two issues to r4; port 2 addresses r4 but is disabled.
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1, 4, 0, 4, 1, 4);
            sb.push_back('{$sformatf("iss4_%0d", i), 32'h0, (i != 0), 32'h0, 1'b0});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
                errors++;
                $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
            end
            tick();
        end

        // Issue and write together leave pend[4] at 2; then two writes retire it.
        drive(1, 4, 32'h44, 1, 4, 0, 4, 1, 4);
        sb.push_back('{"iss_wr4", BYP ? 32'h44 : 32'h0, 1'b1, 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        drive(1, 4, 32'h45, 1, 4, 0, 4, 0, 0);
        sb.push_back('{"wr4_pend2", BYP ? 32'h45 : 32'h44, 1'b1, 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        drive(0, 0, 0, 1, 4, 1, 4, 0, 0);
        sb.push_back('{"pend4_1", 32'h45, 1'b1, 32'h45, 1'b1});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        drive(1, 4, 32'h46, 1, 4, 0, 4, 0, 0);
        sb.push_back('{"wr4_pend1", BYP ? 32'h46 : 32'h45, !BYP, 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        // Untracked write at pend==0 must not wrap the counter.
        drive(1, 4, 32'h47, 1, 4, 0, 4, 0, 0);
        sb.push_back('{"wr4_untracked", BYP ? 32'h47 : 32'h46, 1'b0, 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        drive(0, 0, 0, 1, 4, 0, 0, 0, 0);
        sb.push_back('{"pend4_floor", 32'h47, 1'b0, 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        // Four issues: the fourth lands at pend==3 and must hold there.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 4, 0, 0, 1, 4);
            sb.push_back('{$sformatf("sat_iss%0d", i), 32'h47, (i != 0), 32'h0, 1'b0});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
                errors++;
                $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
            end
            tick();
        end

        // Three writes retire the saturated count; only the last may bypass busy.
        prev = 32'h47;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4, 32'h50 + i, 1, 4, 0, 0, 0, 0);
            sb.push_back('{$sformatf("sat_wr%0d", i), BYP ? 32'h50 + i : prev, !(BYP && i == 2), 32'h0, 1'b0});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
                errors++;
                $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
            end
            tick();
            prev = 32'h50 + i;
        end

        drive(0, 0, 0, 1, 4, 0, 0, 0, 0);
        sb.push_back('{"sat_drained", 32'h52, 1'b0, 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();
    endtask

    task automatic test_async_reset();
        drive(1, 6, 32'h60, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 6);
            tick();
        end

        drive(0, 0, 0, 1, 6, 1, 3, 0, 0);
        sb.push_back('{"pend6_2", 32'h60, 1'b1, 32'h12345678, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        // Assert reset between edges; outputs must drop without a clock.
        #1 rst = 1'b0;
        #1;
        sb.push_back('{"rst_mid", 32'h0, 1'b0, 32'h0, 1'b0});
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();

        // State itself was cleared, not only the outputs.
        drive(0, 0, 0, 1, 6, 1, 3, 0, 0);
        sb.push_back('{"post_rst", 32'h0, 1'b0, 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        drive(1, 6, 32'h77, 1, 6, 0, 0, 0, 0);
        sb.push_back('{"wr6_post", BYP ? 32'h77 : 32'h0, 1'b0, 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();

        drive(0, 0, 0, 1, 6, 0, 0, 0, 0);
        sb.push_back('{"rd6_post", 32'h77, 1'b0, 32'h0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({rdata1, busy1, rdata2, busy2} !== {e.rd1, e.bz1, e.rd2, e.bz2}) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.name, rdata1, busy1, rdata2, busy2, e.rd1, e.bz1, e.rd2, e.bz2);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        test_reset();
        test_write_latency();
        test_bypass();
        test_scoreboard();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wb_regfile
